// File: rtl/rv32i_lsu.sv
// rv32i_lsu: single-outstanding load/store unit between the core and an
// ack-based memory bus, with lane steering, load extension and a bus timeout.
module rv32i_lsu #(
    parameter int XLEN           = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [XLEN-1:0]       req_wdata,
    output logic                  resp_valid,
    output logic [XLEN-1:0]       resp_rdata,
    output logic [1:0]            resp_err,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [XLEN-1:0]       bus_wrdata,
    output logic [XLEN/8-1:0]     bus_byteen,
    output logic                  bus_wren,
    output logic                  bus_rden,
    input  logic                  bus_ack,
    input  logic [XLEN-1:0]       bus_rddata
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    localparam logic [1:0] E_OK    = 2'b00;
    localparam logic [1:0] E_MISAL = 2'b01;
    localparam logic [1:0] E_TMO   = 2'b10;
    localparam logic [1:0] E_SIZE  = 2'b11;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0]            state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  we_q;
    logic [1:0]            size_q;
    logic                  uns_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [XLEN-1:0]       wdata_q;
    logic [XLEN-1:0]       rdata_q, rdata_d;
    logic [1:0]            err_q, err_d;

    logic                  accept;
    logic                  in_access;
    logic                  req_bad_size;
    logic                  req_misal;
    logic [OFFW-1:0]       off;
    logic [XLEN-1:0]       lane_mask;
    logic [7:0]            be8;
    logic [NB-1:0]         size_be;
    logic [XLEN-1:0]       rd_shift;
    logic                  sign_bit;
    logic [XLEN-1:0]       ld_ext;

    function automatic logic [XLEN-1:0] data_mask(input logic [1:0] sz);
        logic [63:0] m;
        m = '1;
        unique case (sz)
            2'd0:    m = 64'h0000_0000_0000_00ff;
            2'd1:    m = 64'h0000_0000_0000_ffff;
            2'd2:    m = 64'h0000_0000_ffff_ffff;
            default: m = '1;
        endcase
        return m[XLEN-1:0];
    endfunction

    assign req_ready = (state_q == S_IDLE);
    assign accept    = req_valid && req_ready;
    assign in_access = (state_q == S_ACCESS);
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    // dword only exists on a 64-bit data bus
    assign req_bad_size = (req_size == 2'd3) && (XLEN == 32);

    always_comb begin
        req_misal = 1'b0;
        unique case (req_size)
            2'd1:    req_misal = req_addr[0];
            2'd2:    req_misal = |req_addr[1:0];
            2'd3:    req_misal = |req_addr[2:0];
            default: req_misal = 1'b0;
        endcase
    end

    assign off       = addr_q[OFFW-1:0];
    assign lane_mask = data_mask(size_q);

    always_comb begin
        be8 = 8'hff;
        unique case (size_q)
            2'd0:    be8 = 8'h01;
            2'd1:    be8 = 8'h03;
            2'd2:    be8 = 8'h0f;
            default: be8 = 8'hff;
        endcase
    end

    assign size_be = be8[NB-1:0];

    assign bus_rden   = in_access && !we_q;
    assign bus_wren   = in_access && we_q;
    assign bus_byteen = in_access ? (size_be << off) : '0;
    assign bus_wrdata = in_access ? ((wdata_q & lane_mask) << {off, 3'b000}) : '0;
    assign bus_addr   = in_access ? {addr_q[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}} : '0;

    assign rd_shift = bus_rddata >> {off, 3'b000};

    always_comb begin
        sign_bit = rd_shift[XLEN-1];
        unique case (size_q)
            2'd0:    sign_bit = rd_shift[7];
            2'd1:    sign_bit = rd_shift[15];
            2'd2:    sign_bit = rd_shift[31];
            default: sign_bit = rd_shift[XLEN-1];
        endcase
    end

    assign ld_ext = (rd_shift & lane_mask)
                  | ((!uns_q && sign_bit) ? ~lane_mask : '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_bad_size) begin
                        state_d = S_RESP;
                        err_d   = E_SIZE;
                        rdata_d = '0;
                    end else if (req_misal) begin
                        state_d = S_RESP;
                        err_d   = E_MISAL;
                        rdata_d = '0;
                    end else begin
                        state_d = S_ACCESS;
                        cnt_d   = '0;
                    end
                end
            end
            S_ACCESS: begin
                // an ack on the last allowed cycle still wins over the timeout
                if (bus_ack) begin
                    state_d = S_RESP;
                    err_d   = E_OK;
                    rdata_d = we_q ? '0 : ld_ext;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_RESP;
                    err_d   = E_TMO;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= E_OK;
            we_q    <= 1'b0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                we_q    <= req_we;
                size_q  <= req_size;
                uns_q   <= req_unsigned;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
        end
    end

endmodule

// File: tb/tb_rv32i_lsu.sv
// Bench for rv32i_lsu: directed table, hand sequences and random traffic
// on a 32-bit instance (short timeout) plus a 64-bit instance.
module tb_rv32i_lsu;

    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        int          waitn;
        logic [1:0]  err;
        logic [31:0] rdata;
        logic [3:0]  be;
        logic [31:0] wr;
        logic [31:0] ba;
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        a_req_valid, a_req_ready, a_req_we, a_req_unsigned;
    logic [1:0]  a_req_size;
    logic [31:0] a_req_addr, a_req_wdata;
    logic        a_resp_valid;
    logic [31:0] a_resp_rdata;
    logic [1:0]  a_resp_err;
    logic [31:0] a_bus_addr, a_bus_wrdata, a_bus_rddata;
    logic [3:0]  a_bus_byteen;
    logic        a_bus_wren, a_bus_rden, a_bus_ack;

    logic        b_req_valid, b_req_ready, b_req_we, b_req_unsigned;
    logic [1:0]  b_req_size;
    logic [31:0] b_req_addr;
    logic [63:0] b_req_wdata;
    logic        b_resp_valid;
    logic [63:0] b_resp_rdata;
    logic [1:0]  b_resp_err;
    logic [31:0] b_bus_addr;
    logic [63:0] b_bus_wrdata, b_bus_rddata;
    logic [7:0]  b_bus_byteen;
    logic        b_bus_wren, b_bus_rden, b_bus_ack;

    rv32i_lsu #(.XLEN(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) u_a (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_we(a_req_we), .req_size(a_req_size),
        .req_unsigned(a_req_unsigned), .req_addr(a_req_addr),
        .req_wdata(a_req_wdata),
        .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata),
        .resp_err(a_resp_err),
        .bus_addr(a_bus_addr), .bus_wrdata(a_bus_wrdata),
        .bus_byteen(a_bus_byteen), .bus_wren(a_bus_wren),
        .bus_rden(a_bus_rden), .bus_ack(a_bus_ack),
        .bus_rddata(a_bus_rddata)
    );

    rv32i_lsu #(.XLEN(64), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(16)) u_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_we(b_req_we), .req_size(b_req_size),
        .req_unsigned(b_req_unsigned), .req_addr(b_req_addr),
        .req_wdata(b_req_wdata),
        .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata),
        .resp_err(b_resp_err),
        .bus_addr(b_bus_addr), .bus_wrdata(b_bus_wrdata),
        .bus_byteen(b_bus_byteen), .bus_wren(b_bus_wren),
        .bus_rden(b_bus_rden), .bus_ack(b_bus_ack),
        .bus_rddata(b_bus_rddata)
    );

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Reference: byte-lane arithmetic straight from the access rules.
    function automatic vec_t model32(input logic we, input logic [1:0] sz,
                                     input logic uns, input logic [31:0] addr,
                                     input logic [31:0] wd, input logic [31:0] rd,
                                     input int waitn);
        vec_t   v;
        int     n;
        int     off;
        longint val;
        v.name  = "rnd";
        v.we    = we;
        v.sz    = sz;
        v.uns   = uns;
        v.addr  = addr;
        v.wd    = wd;
        v.rd    = rd;
        v.waitn = waitn;
        n       = 1 << sz;
        off     = int'(addr % 4);
        v.ba    = addr - 32'(off);
        v.be    = '0;
        v.wr    = '0;
        v.rdata = '0;
        if (sz == 2'd3) v.err = 2'b11;
        else if ((addr % n) != 0) v.err = 2'b01;
        else v.err = 2'b00;
        if (v.err == 2'b00) begin
            for (int i = 0; i < n; i++) begin
                v.be[off+i] = 1'b1;
                v.wr[8*(off+i) +: 8] = wd[8*i +: 8];
            end
            if (!we) begin
                val = 0;
                for (int i = 0; i < n; i++)
                    val += longint'(rd[8*(off+i) +: 8]) << (8*i);
                if (!uns && val >= (64'sd1 << (8*n-1)))
                    val -= (64'sd1 << (8*n));
                v.rdata = val[31:0];
            end
        end
        v.lat = (v.err != 2'b00) ? 1 : waitn + 2;
        return v;
    endfunction

    task automatic run32(input vec_t v);
        int lat;
        int acc;
        @(negedge clk);
        chk({v.name, ".ready"}, 64'(a_req_ready), 64'd1);
        a_req_valid    = 1'b1;
        a_req_we       = v.we;
        a_req_size     = v.sz;
        a_req_unsigned = v.uns;
        a_req_addr     = v.addr;
        a_req_wdata    = v.wd;
        @(negedge clk);
        a_req_valid    = 1'b0;
        a_req_we       = 1'($urandom);
        a_req_size     = 2'($urandom);
        a_req_unsigned = 1'($urandom);
        a_req_addr     = $urandom;
        a_req_wdata    = $urandom;
        lat = 1;
        acc = 0;
        while (!a_resp_valid && lat < 20) begin
            acc++;
            chk({v.name, ".rden"}, 64'(a_bus_rden), 64'(!v.we));
            chk({v.name, ".wren"}, 64'(a_bus_wren), 64'(v.we));
            if (acc == 1) begin
                chk({v.name, ".byteen"}, 64'(a_bus_byteen), 64'(v.be));
                chk({v.name, ".bus_addr"}, 64'(a_bus_addr), 64'(v.ba));
                chk({v.name, ".wrdata"}, 64'(a_bus_wrdata), 64'(v.wr));
            end
            if (v.waitn >= 0 && acc == v.waitn + 1) begin
                a_bus_ack    = 1'b1;
                a_bus_rddata = v.rd;
            end
            @(negedge clk);
            a_bus_ack    = 1'b0;
            a_bus_rddata = $urandom;
            lat++;
        end
        chk({v.name, ".resp_valid"}, 64'(a_resp_valid), 64'd1);
        chk({v.name, ".latency"}, 64'(lat), 64'(v.lat));
        chk({v.name, ".err"}, 64'(a_resp_err), 64'(v.err));
        chk({v.name, ".rdata"}, 64'(a_resp_rdata), 64'(v.rdata));
        a_bus_ack = 1'b1;
        @(negedge clk);
        a_bus_ack = 1'b0;
        chk({v.name, ".pulse"}, 64'(a_resp_valid), 64'd0);
        chk({v.name, ".idle"}, 64'(a_req_ready), 64'd1);
        chk({v.name, ".hold"}, 64'(a_resp_rdata), 64'(v.rdata));
    endtask

    task automatic run64(input string nm, input logic we, input logic [1:0] sz,
                         input logic uns, input logic [31:0] addr,
                         input logic [63:0] wd, input logic [63:0] rd,
                         input logic [7:0] be, input logic [31:0] ba,
                         input logic [63:0] wr, input logic [63:0] rdata);
        @(negedge clk);
        b_req_valid    = 1'b1;
        b_req_we       = we;
        b_req_size     = sz;
        b_req_unsigned = uns;
        b_req_addr     = addr;
        b_req_wdata    = wd;
        @(negedge clk);
        b_req_valid = 1'b0;
        chk({nm, ".rden"}, 64'(b_bus_rden), 64'(!we));
        chk({nm, ".wren"}, 64'(b_bus_wren), 64'(we));
        chk({nm, ".byteen"}, 64'(b_bus_byteen), 64'(be));
        chk({nm, ".bus_addr"}, 64'(b_bus_addr), 64'(ba));
        chk({nm, ".wrdata"}, b_bus_wrdata, wr);
        b_bus_ack    = 1'b1;
        b_bus_rddata = rd;
        @(negedge clk);
        b_bus_ack    = 1'b0;
        b_bus_rddata = '0;
        chk({nm, ".resp_valid"}, 64'(b_resp_valid), 64'd1);
        chk({nm, ".err"}, 64'(b_resp_err), 64'd0);
        chk({nm, ".rdata"}, b_resp_rdata, rdata);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl[11];
        vec_t v;
        logic [1:0]  sz;
        logic [31:0] addr;

        tbl[0]  = '{name:"LB",     we:1'b0, sz:2'd0, uns:1'b0, addr:32'h103, wd:32'h0,
                    rd:32'h80FF_FF12, waitn:0, err:2'b00, rdata:32'hFFFF_FF80,
                    be:4'h8, wr:32'h0, ba:32'h100, lat:2};
        tbl[1]  = '{name:"SH",     we:1'b1, sz:2'd1, uns:1'b0, addr:32'h202, wd:32'h0000_ABCD,
                    rd:32'h0, waitn:1, err:2'b00, rdata:32'h0,
                    be:4'hC, wr:32'hABCD_0000, ba:32'h200, lat:3};
        tbl[2]  = '{name:"MISAL",  we:1'b0, sz:2'd2, uns:1'b0, addr:32'h301, wd:32'h0,
                    rd:32'h0, waitn:0, err:2'b01, rdata:32'h0,
                    be:4'h0, wr:32'h0, ba:32'h0, lat:1};
        tbl[3]  = '{name:"ILLSZ",  we:1'b0, sz:2'd3, uns:1'b0, addr:32'h400, wd:32'h0,
                    rd:32'h0, waitn:0, err:2'b11, rdata:32'h0,
                    be:4'h0, wr:32'h0, ba:32'h0, lat:1};
        tbl[4]  = '{name:"TMO",    we:1'b0, sz:2'd2, uns:1'b0, addr:32'h500, wd:32'h0,
                    rd:32'h0, waitn:-1, err:2'b10, rdata:32'h0,
                    be:4'hF, wr:32'h0, ba:32'h500, lat:5};
        tbl[5]  = '{name:"PRIO",   we:1'b0, sz:2'd2, uns:1'b0, addr:32'h504, wd:32'h0,
                    rd:32'h1234_5678, waitn:3, err:2'b00, rdata:32'h1234_5678,
                    be:4'hF, wr:32'h0, ba:32'h504, lat:5};
        tbl[6]  = '{name:"LHU",    we:1'b0, sz:2'd1, uns:1'b1, addr:32'h602, wd:32'h0,
                    rd:32'hBEEF_0000, waitn:0, err:2'b00, rdata:32'h0000_BEEF,
                    be:4'hC, wr:32'h0, ba:32'h600, lat:2};
        tbl[7]  = '{name:"LH",     we:1'b0, sz:2'd1, uns:1'b0, addr:32'h602, wd:32'h0,
                    rd:32'hBEEF_0000, waitn:0, err:2'b00, rdata:32'hFFFF_BEEF,
                    be:4'hC, wr:32'h0, ba:32'h600, lat:2};
        tbl[8]  = '{name:"SB",     we:1'b1, sz:2'd0, uns:1'b0, addr:32'h701, wd:32'hFFFF_FF5A,
                    rd:32'h0, waitn:0, err:2'b00, rdata:32'h0,
                    be:4'h2, wr:32'h0000_5A00, ba:32'h700, lat:2};
        tbl[9]  = '{name:"SHMIS",  we:1'b1, sz:2'd1, uns:1'b0, addr:32'h801, wd:32'h1234,
                    rd:32'h0, waitn:0, err:2'b01, rdata:32'h0,
                    be:4'h0, wr:32'h0, ba:32'h0, lat:1};
        tbl[10] = '{name:"LBU",    we:1'b0, sz:2'd0, uns:1'b1, addr:32'h900, wd:32'h0,
                    rd:32'h1234_56F0, waitn:2, err:2'b00, rdata:32'h0000_00F0,
                    be:4'h1, wr:32'h0, ba:32'h900, lat:4};

        rst            = 1'b0;
        a_req_valid    = 1'b0;
        a_req_we       = 1'b0;
        a_req_size     = 2'd0;
        a_req_unsigned = 1'b0;
        a_req_addr     = '0;
        a_req_wdata    = '0;
        a_bus_ack      = 1'b0;
        a_bus_rddata   = '0;
        b_req_valid    = 1'b0;
        b_req_we       = 1'b0;
        b_req_size     = 2'd0;
        b_req_unsigned = 1'b0;
        b_req_addr     = '0;
        b_req_wdata    = '0;
        b_bus_ack      = 1'b0;
        b_bus_rddata   = '0;

        repeat (2) @(negedge clk);
        chk("rst.ready", 64'(a_req_ready), 64'd1);
        chk("rst.resp_valid", 64'(a_resp_valid), 64'd0);
        chk("rst.rdata", 64'(a_resp_rdata), 64'd0);
        chk("rst.err", 64'(a_resp_err), 64'd0);
        chk("rst.strobes", 64'({a_bus_rden, a_bus_wren}), 64'd0);
        chk("rst.byteen", 64'(a_bus_byteen), 64'd0);
        chk("rst.bus_addr", 64'(a_bus_addr), 64'd0);
        chk("rst.wrdata", 64'(a_bus_wrdata), 64'd0);
        rst = 1'b1;

        for (int i = 0; i < 11; i++) run32(tbl[i]);

        // reset in the middle of a bus access
        @(negedge clk);
        a_req_valid = 1'b1;
        a_req_we    = 1'b0;
        a_req_size  = 2'd2;
        a_req_addr  = 32'hA00;
        @(negedge clk);
        a_req_valid = 1'b0;
        chk("midrst.rden_before", 64'(a_bus_rden), 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("midrst.rden_drop", 64'(a_bus_rden), 64'd0);
        chk("midrst.rdata_clr", 64'(a_resp_rdata), 64'd0);
        @(negedge clk);
        chk("midrst.no_resp", 64'(a_resp_valid), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst.ready", 64'(a_req_ready), 64'd1);
        chk("midrst.no_resp2", 64'(a_resp_valid), 64'd0);
        @(negedge clk);
        chk("midrst.no_resp3", 64'(a_resp_valid), 64'd0);

        run64("LWU64", 1'b0, 2'd2, 1'b1, 32'h1004, 64'h0,
              64'h8765_4321_0000_0000, 8'hF0, 32'h1000, 64'h0,
              64'h0000_0000_8765_4321);
        run64("LW64", 1'b0, 2'd2, 1'b0, 32'h1004, 64'h0,
              64'h8765_4321_0000_0000, 8'hF0, 32'h1000, 64'h0,
              64'hFFFF_FFFF_8765_4321);
        run64("LD64", 1'b0, 2'd3, 1'b0, 32'h2008, 64'h0,
              64'hDEAD_BEEF_0123_4567, 8'hFF, 32'h2008, 64'h0,
              64'hDEAD_BEEF_0123_4567);
        run64("SH64", 1'b1, 2'd1, 1'b0, 32'h3006, 64'hFFFF_FFFF_FFFF_1234,
              64'h0, 8'hC0, 32'h3000, 64'h1234_0000_0000_0000, 64'h0);

        for (int i = 0; i < 40; i++) begin
            sz   = 2'($urandom);
            addr = $urandom;
            if ($urandom_range(0, 3) != 0)
                addr = addr & ~((32'd1 << sz) - 32'd1);
            v = model32(1'($urandom), sz, 1'($urandom), addr,
                        $urandom, $urandom, int'($urandom_range(0, 3)));
            run32(v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
